// File: rtl/ws2812_driver_if.sv
// Bundles the driver's RAM read port, refresh handshake and serial line.
// The slave side is the driver; the master side is the host/RAM that feeds it.
interface ws2812_driver_if #(
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] addr_out;
    logic          rw;
    logic [23:0]   data_in;
    logic          busy;
    logic          done;
    logic          dout;

    modport master (output start, data_in, input addr_out, rw, busy, done, dout);
    modport slave  (input start, data_in, output addr_out, rw, busy, done, dout);
endinterface

// File: rtl/ws2812_driver.sv
// WS2812 strip refresher: per LED reads one RRGGBB word, sends 24 GRB bits MSB first, then a latch gap.
// All outputs registered; first bit starts 2 cycles after start; no backpressure, start is ignored while busy.
module ws2812_driver #(
    parameter int NLEDS = 14,
    parameter int AW    = 6,
    parameter int T0H   = 20,
    parameter int T0L   = 43,
    parameter int T1H   = 40,
    parameter int T1L   = 23,
    parameter int TRST  = 2600
) (
    input  logic            clk,
    input  logic            rst,
    ws2812_driver_if.slave  bus
);
    localparam int TM_A = (T0H > T0L) ? T0H : T0L;
    localparam int TM_B = (T1H > T1L) ? T1H : T1L;
    localparam int TM_C = (TM_A > TM_B) ? TM_A : TM_B;
    localparam int TMAX = (TM_C > TRST) ? TM_C : TRST;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HIGH, LOW, GAP, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, addr_q, addr_d;
    logic [23:0]   sh_q, sh_d;
    logic [4:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hi_last, lo_last;
    logic          dout_q, dout_d, rw_q, rw_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        hi_last = sh_q[23] ? CW'(T1H - 1) : CW'(T0H - 1);
        lo_last = sh_q[23] ? CW'(T1L - 1) : CW'(T0L - 1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                sh_d    = {bus.data_in[15:8], bus.data_in[23:16], bus.data_in[7:0]};
                bit_d   = '0;
                cnt_d   = '0;
                state_d = HIGH;
            end
            HIGH: begin
                if (cnt_q == hi_last) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == lo_last) begin
                    cnt_d = '0;
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd23) begin
                        // FETCH+LOAD of the next word become the 2 extra low cycles
                        if (idx_q < AW'(NLEDS - 1)) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(TRST - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with state_q
        dout_d = (state_d == HIGH);
        rw_d   = (state_d == FETCH);
        addr_d = (state_d == FETCH) ? idx_d : addr_q;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.addr_out = addr_q;
    assign bus.rw       = rw_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dout     = dout_q;
endmodule

// File: tb/tb_ws2812_driver.sv
// Directed bench: a 1-LED and a 14-LED driver share one serial-line decoder selected by sel14.
module tb_ws2812_driver;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst1, rst14, sel14, mon_clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    ws2812_driver_if #(.AW(6)) b1 ();
    ws2812_driver_if #(.AW(6)) b14 ();

    ws2812_driver #(.NLEDS(1))  u1  (.clk(clk), .rst(rst1),  .bus(b1));
    ws2812_driver #(.NLEDS(14)) u14 (.clk(clk), .rst(rst14), .bus(b14));

    logic [23:0] ram1  [0:63];
    logic [23:0] ram14 [0:63];

    always @(posedge clk) begin
        if (b1.rw)  b1.data_in  <= ram1[b1.addr_out];
        if (b14.rw) b14.data_in <= ram14[b14.addr_out];
    end

    logic       m_dout, m_busy, m_done, m_rw;
    logic [5:0] m_addr;
    assign m_dout = sel14 ? b14.dout     : b1.dout;
    assign m_busy = sel14 ? b14.busy     : b1.busy;
    assign m_done = sel14 ? b14.done     : b1.done;
    assign m_rw   = sel14 ? b14.rw       : b1.rw;
    assign m_addr = sel14 ? b14.addr_out : b1.addr_out;

    // Serial decoder: a bit is 1 when its high run is 40 cycles; every run length is checked
    int         hi_len, lo_len, nbits, tim_err, busy_len, done_cnt, nfetch, gap_len, exp_lo;
    logic       prev_dout;
    logic       bits [0:511];
    logic [5:0] fetch_addr [0:31];

    initial begin
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                hi_len = 0; lo_len = 0; nbits = 0; tim_err = 0; busy_len = 0;
                done_cnt = 0; nfetch = 0; gap_len = 0; prev_dout = 1'b0;
            end else begin
                if (m_busy) busy_len++;
                if (m_done) done_cnt++;
                if (m_rw) begin
                    if (nfetch < 32) fetch_addr[nfetch] = m_addr;
                    nfetch++;
                end
                if (m_dout) begin
                    if (!prev_dout) begin
                        if (nbits > 0) begin
                            exp_lo = (bits[nbits-1] ? 23 : 43) + ((nbits % 24 == 0) ? 2 : 0);
                            if (lo_len != exp_lo) tim_err++;
                        end
                        lo_len = 0;
                        hi_len = 0;
                    end
                    hi_len++;
                end else begin
                    if (prev_dout) begin
                        if (hi_len != 20 && hi_len != 40) tim_err++;
                        if (nbits < 512) bits[nbits] = (hi_len == 40);
                        nbits++;
                        lo_len = 0;
                    end
                    lo_len++;
                end
                if (m_done) gap_len = lo_len;
                prev_dout = m_dout;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] led_word(input int led);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) w = {w[22:0], bits[led*24 + i]};
        return w;
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel14) b14.start = 1'b1; else b1.start = 1'b1;
        @(negedge clk);
        b1.start  = 1'b0;
        b14.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t = 0;
        while (!m_done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < budget), 32'd1);
    endtask

    initial begin
        int t;
        sel14 = 1'b0; mon_clr = 1'b0;
        rst1 = 1'b1; rst14 = 1'b1;
        b1.start = 1'b0; b14.start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ram1[i]  = 24'hFF0000;
            ram14[i] = 24'hFF0000;
        end
        repeat (3) @(negedge clk);

        chk("rst_dout",  32'(b1.dout),     32'd0);
        chk("rst_busy",  32'(b1.busy),     32'd0);
        chk("rst_done",  32'(b1.done),     32'd0);
        chk("rst_rw",    32'(b1.rw),       32'd0);
        chk("rst_addr",  32'(b14.addr_out), 32'd0);
        chk("rst_busy14", 32'(b14.busy),   32'd0);
        rst1 = 1'b0; rst14 = 1'b0;
        clear_mon();

        // One LED, word FF0000: GRB reorder gives G=00,R=FF,B=00 on the wire
        pulse_start();
        wait_done("one_done_timeout", 6000);
        @(negedge clk);
        chk("one_busy_after_done", 32'(b1.busy), 32'd0);
        chk("one_busy_len",   32'(busy_len), 32'd4115);
        chk("one_done_cnt",   32'(done_cnt), 32'd1);
        chk("one_nbits",      32'(nbits),    32'd24);
        chk("one_stream",     32'(led_word(0)), 32'h00FF00);
        chk("one_timing",     32'(tim_err),  32'd0);
        chk("one_gap",        32'(gap_len),  32'd2644);
        chk("one_fetches",    32'(nfetch),   32'd1);

        // Byte reorder of a mixed word
        ram1[0] = 24'h123456;
        clear_mon();
        pulse_start();
        wait_done("grb_done_timeout", 6000);
        chk("grb_stream", 32'(led_word(0)), 32'h341256);
        chk("grb_timing", 32'(tim_err), 32'd0);

        // start held through the whole frame including the DONE cycle
        clear_mon();
        b1.start = 1'b1;
        wait_done("hold_done_timeout", 6000);
        @(negedge clk);
        b1.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_done_cnt", 32'(done_cnt), 32'd1);
        chk("hold_fetches",  32'(nfetch),   32'd1);
        chk("hold_busy",     32'(b1.busy),  32'd0);

        // 14 LEDs; word 5 rewritten while LED 2 is on the wire
        sel14 = 1'b1;
        clear_mon();
        pulse_start();
        t = 0;
        while (!(m_rw && m_addr == 6'd2) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("led2_fetch_timeout", 32'(t < 5000), 32'd1);
        repeat (100) @(negedge clk);
        ram14[5] = 24'h123456;
        wait_done("strip_done_timeout", 30000);
        chk("strip_fetches",  32'(nfetch),   32'd14);
        for (int i = 0; i < 14; i++) chk($sformatf("strip_addr%0d", i), 32'(fetch_addr[i]), 32'(i));
        chk("strip_nbits",    32'(nbits),    32'd336);
        for (int i = 0; i < 14; i++)
            chk($sformatf("strip_led%0d", i), 32'(led_word(i)), (i == 5) ? 32'h341256 : 32'h00FF00);
        chk("strip_timing",   32'(tim_err),  32'd0);
        chk("strip_done_cnt", 32'(done_cnt), 32'd1);
        chk("strip_busy_len", 32'(busy_len), 32'd23797);
        chk("strip_gap",      32'(gap_len),  32'd2644);

        // Reset during bit 10 of LED 3
        ram14[5] = 24'hFF0000;
        clear_mon();
        pulse_start();
        t = 0;
        while (!(nbits == 82 && m_dout) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        chk("bit82_timeout", 32'(t < 10000), 32'd1);
        rst14 = 1'b1;
        #1;
        chk("mid_rst_dout", 32'(b14.dout), 32'd0);
        chk("mid_rst_busy", 32'(b14.busy), 32'd0);
        chk("mid_rst_rw",   32'(b14.rw),   32'd0);
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        rst14 = 1'b0;
        clear_mon();
        pulse_start();
        t = 0;
        while (nfetch == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("restart_fetch", 32'(nfetch), 32'd1);
        chk("restart_addr0", 32'(fetch_addr[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
